zero_pad_seq: RTL

//  Sequences the write-out of one compressed block to the memory controller.

---
 rtl/zero_pad_seq_if.sv | 20 ++
 rtl/zero_pad_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/zero_pad_seq_if.sv
// -----------------------------------------------------------------------------
// zero_pad_seq_if
// Word stream handshake used on both sides of the zero-pad sequencer.
//   valid  : word on data/eop is valid (driven by master)
//   ready  : receiver accepts the word (driven by slave)
//   data   : DW-bit data word
//   eop    : marks the last word of a packet/slot
// A beat is valid & ready on the same rising edge.
// -----------------------------------------------------------------------------
interface zero_pad_seq_if #(
    parameter int DW = 64
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          eop;

    modport master (output valid, output data, output eop, input ready);
    modport slave  (input valid, input data, input eop, output ready);
endinterface

// File: rtl/zero_pad_seq.sv
// -----------------------------------------------------------------------------
// zero_pad_seq
// Sequences the write-out of one compressed block into a fixed BLK_WORDS slot:
// forwards comp_size_i+1 engine words unchanged, then emits all-zero words
// until the slot is full, flagging the final slot word with eop.
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst          in   asynchronous active-high reset
//   start_i      in   begin a block (sampled only while idle)
//   comp_size_i  in   compressed length minus 1
//   eng          slave  stream from compression engine (eng.eop checked only)
//   mem          master stream toward memory-controller write port
//   busy_o       out  block in progress
//   done_o       out  one-cycle pulse after final slot word accepted
//   err_o        out  sticky: engine eop did not match the expected last word
//   pad_cnt_o    out  (ZPAD_STAT_EN only) saturating count of pad beats
//
// Configuration
//   ZPAD_STAT_EN : when defined, adds pad_cnt_o and its counter.
// -----------------------------------------------------------------------------
module zero_pad_seq #(
    parameter int DW        = 64,
    parameter int BLK_WORDS = 8,
    parameter int CW        = $clog2(BLK_WORDS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [CW-1:0]  comp_size_i,
    zero_pad_seq_if.slave  eng,
    zero_pad_seq_if.master mem,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
`ifdef ZPAD_STAT_EN
    ,
    output logic [31:0]    pad_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(BLK_WORDS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] len_r;
    logic [CW-1:0] cnt_r;
    logic          at_len;
    logic          beat;
    logic          last_beat;
    logic          err_set;

    assign at_len = (cnt_r == len_r);
    assign busy_o = (state_q != IDLE);

    // Next-state and stream outputs. DATA is a zero-latency pass-through so
    // the engine sees the memory controller's ready directly.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        eng.ready = 1'b0;
        mem.valid = 1'b0;
        mem.data  = '0;
        mem.eop   = 1'b0;
        beat      = 1'b0;
        last_beat = 1'b0;
        err_set   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) state_d = DATA;
            end
            DATA: begin
                mem.valid = eng.valid;
                mem.data  = eng.data;
                eng.ready = mem.ready;
                // Only a full-length block ends the slot with engine data.
                mem.eop   = at_len && (len_r == LAST);
                beat      = eng.valid && mem.ready;
                err_set   = beat && (eng.eop != at_len);
                if (beat && at_len) begin
                    if (len_r == LAST) begin
                        state_d   = IDLE;
                        last_beat = 1'b1;
                    end else begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                mem.valid = 1'b1;
                mem.eop   = (cnt_r == LAST);
                beat      = mem.ready;
                if (beat && cnt_r == LAST) begin
                    state_d   = IDLE;
                    last_beat = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r  <= '0;
            cnt_r  <= '0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            done_o <= last_beat;
            if (err_set) err_o <= 1'b1;
            if (state_q == IDLE && start_i) begin
                len_r <= comp_size_i;
                cnt_r <= '0;
            end else if (beat && !last_beat) begin
                // The final beat does not advance, so cnt_r never wraps.
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

`ifdef ZPAD_STAT_EN
    logic pad_beat;
    assign pad_beat = (state_q == PAD) && mem.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              pad_cnt_o <= '0;
        else if (pad_beat && pad_cnt_o != '1) pad_cnt_o <= pad_cnt_o + 32'd1;
    end
`endif

endmodule
